bdd_walk_ctrl: RTL and testbench

- Sequencer for the decision-diagram classification datapath: walks the node graph from the root for one attribute vector.
- Per node: reads the coefficient/threshold word and the child-pointer word, runs the MAC, compares, then follows the left or right child until it reaches a leaf.
- Sits between the host request interface and the node SRAMs/MAC. Replaces the free-running feedback of next_addr with an explicit handshaked FSM that has a depth guard.

---
 rtl/bdd_walk_ctrl.sv | 111 +++++++++++
 tb/tb_bdd_walk_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bdd_walk_ctrl.sv
// bdd_walk_ctrl: decision-diagram walk sequencer (host req/res handshake, node SRAM read, MAC start/done, leaf class or depth-abort result)
module bdd_walk_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int THRESH_WIDTH = 10,
  parameter int ACC_WIDTH = 16,
  parameter int MEM_LAT = 1,
  parameter int MAX_DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] ROOT_ADDR = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  output logic                        node_rd,
  output logic [ADDR_WIDTH-1:0]       node_addr,
  input  logic [THRESH_WIDTH-1:0]     thresh_in,
  input  logic [2*(ADDR_WIDTH+1)-1:0] child_in,
  output logic                        mac_start,
  input  logic                        mac_done,
  input  logic [ACC_WIDTH-1:0]        mac_acc,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ADDR_WIDTH-1:0]       res_class,
  output logic                        res_err,
  output logic                        busy
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int MW = ACC_WIDTH > THRESH_WIDTH ? ACC_WIDTH : THRESH_WIDTH;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, MAC, DONE} state_t;
  state_t state;
  logic [DW-1:0] depth;
  logic [LW-1:0] lat;
  logic [THRESH_WIDTH-1:0] thr_r;
  logic [CW-1:0] left_r, right_r, sel;
  logic [DW-1:0] depth_nx;
  assign sel = MW'(mac_acc) <= MW'(thr_r) ? left_r : right_r;
  assign depth_nx = depth + DW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      node_rd <= 1'b0;
      node_addr <= ROOT_ADDR;
      mac_start <= 1'b0;
      res_valid <= 1'b0;
      res_class <= '0;
      res_err <= 1'b0;
      busy <= 1'b0;
      depth <= '0;
      lat <= '0;
      thr_r <= '0;
      left_r <= '0;
      right_r <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state <= FETCH;
          req_ready <= 1'b0;
          busy <= 1'b1;
          node_rd <= 1'b1;
          node_addr <= ROOT_ADDR;
          depth <= '0;
        end
        FETCH: begin
          node_rd <= 1'b0;
          lat <= LW'(1);
          mac_start <= MEM_LAT == 1;
          state <= WAIT_MEM;
        end
        WAIT_MEM: if (lat == LW'(MEM_LAT)) begin
          thr_r <= thresh_in;
          {left_r, right_r} <= child_in;
          mac_start <= 1'b0;
          state <= MAC;
        end else begin
          lat <= lat + LW'(1);
          mac_start <= lat + LW'(1) == LW'(MEM_LAT);
        end
        MAC: if (mac_done) begin
          if (sel[ADDR_WIDTH]) begin
            res_class <= sel[ADDR_WIDTH-1:0];
            res_err <= 1'b0;
            res_valid <= 1'b1;
            state <= DONE;
          end else begin
            node_addr <= sel[ADDR_WIDTH-1:0];
            depth <= depth_nx;
            if (depth_nx == DW'(MAX_DEPTH)) begin
              res_class <= '0;
              res_err <= 1'b1;
              res_valid <= 1'b1;
              state <= DONE;
            end else begin
              node_rd <= 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          req_ready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bdd_walk_ctrl.sv
// tb_bdd_walk_ctrl: random and directed walks on two controllers (MEM_LAT=1/MAX_DEPTH=4 and MEM_LAT=3/MAX_DEPTH=16) against a table-walking model
module tb_bdd_walk_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic req_valid [2], req_ready [2], node_rd [2], mac_start [2], mac_done [2];
  logic res_valid [2], res_ready [2], res_err [2], busy [2];
  logic [7:0] node_addr [2], res_class [2];
  logic [9:0] thresh_in [2];
  logic [17:0] child_in [2];
  logic [15:0] mac_acc [2];
  logic [9:0] tt [256];
  logic [17:0] ct [256];
  logic [15:0] at [256];
  int mdel = 0;
  bit spur = 1'b0;
  int cyc = 0;
  int rd_cyc [2] = '{0, 0};
  int gap_bad [2] = '{0, 0};
  logic [7:0] aq [2][$];
  logic [7:0] exq [$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = g == 0 ? 1 : 3;
    localparam int MD = g == 0 ? 4 : 16;
    logic [2:0] sr = '0;
    logic [7:0] ad [3];
    logic [9:0] jt = '0;
    logic [17:0] jc = '0;
    int mc = 0;
    logic [7:0] ma = '0;
    bdd_walk_ctrl #(.MEM_LAT(LAT), .MAX_DEPTH(MD)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .node_rd(node_rd[g]), .node_addr(node_addr[g]), .thresh_in(thresh_in[g]),
      .child_in(child_in[g]), .mac_start(mac_start[g]), .mac_done(mac_done[g]),
      .mac_acc(mac_acc[g]), .res_valid(res_valid[g]), .res_ready(res_ready[g]),
      .res_class(res_class[g]), .res_err(res_err[g]), .busy(busy[g])
    );
    assign thresh_in[g] = sr[LAT-1] ? tt[ad[LAT-1]] : jt;
    assign child_in[g] = sr[LAT-1] ? ct[ad[LAT-1]] : jc;
    always @(posedge clk) begin
      sr <= {sr[1:0], node_rd[g]};
      ad[0] <= node_addr[g];
      ad[1] <= ad[0];
      ad[2] <= ad[1];
      jt <= 10'($urandom);
      jc <= 18'($urandom);
      mac_done[g] <= 1'b0;
      if (mc > 0) mc <= mc - 1;
      if (mc == 1) begin
        mac_done[g] <= 1'b1;
        mac_acc[g] <= at[ma];
      end
      if (mac_start[g]) begin
        if (mdel == 0) begin
          mac_done[g] <= 1'b1;
          mac_acc[g] <= at[node_addr[g]];
        end else begin
          mc <= mdel;
          ma <= node_addr[g];
        end
        if (cyc - rd_cyc[g] != LAT) gap_bad[g] <= gap_bad[g] + 1;
      end
      if (node_rd[g]) begin
        aq[g].push_back(node_addr[g]);
        rd_cyc[g] <= cyc;
        if (spur) begin
          mac_done[g] <= 1'b1;
          mac_acc[g] <= 16'($urandom);
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void model(input int md, output logic [7:0] cls, output logic err);
    int a = 0;
    logic [8:0] h;
    exq.delete();
    for (int d = 1; d <= md; d++) begin
      exq.push_back(8'(a));
      h = at[a] <= 16'(tt[a]) ? ct[a][17:9] : ct[a][8:0];
      if (h[8]) begin
        cls = h[7:0];
        err = 1'b0;
        return;
      end
      a = int'(h[7:0]);
    end
    cls = 8'h00;
    err = 1'b1;
  endfunction
  task automatic walk(input int g, input int md, input int hold, input string tag);
    logic [7:0] ec;
    logic ee;
    int n = 0;
    model(md, ec, ee);
    aq[g].delete();
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready[g]), 1);
    req_valid[g] = 1'b1;
    @(negedge clk);
    req_valid[g] = 1'b0;
    chk({tag, ".first_rd"}, {23'd0, node_rd[g], node_addr[g]}, 32'h100);
    while (res_valid[g] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".res_valid"}, 32'(res_valid[g]), 1);
    chk({tag, ".class"}, 32'(res_class[g]), 32'(ec));
    chk({tag, ".err"}, 32'(res_err[g]), 32'(ee));
    chk({tag, ".visits"}, aq[g].size(), exq.size());
    for (int i = 0; i < exq.size() && i < aq[g].size(); i++) chk({tag, ".path"}, 32'(aq[g][i]), 32'(exq[i]));
    chk({tag, ".gap"}, gap_bad[g], 0);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, ".hold"}, {22'd0, busy[g], res_valid[g], res_err[g], res_class[g]}, {22'd0, 2'b11, ee, ec});
    end
    res_ready[g] = 1'b1;
    @(negedge clk);
    res_ready[g] = 1'b0;
    chk({tag, ".release"}, {29'd0, res_valid[g], req_ready[g], busy[g]}, 32'b010);
  endtask
  initial begin
    int n;
    rst = 1'b1;
    req_valid = '{1'b0, 1'b0};
    res_ready = '{1'b0, 1'b0};
    for (int i = 0; i < 256; i++) begin
      tt[i] = '0;
      ct[i] = '0;
      at[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk("reset", {req_ready[g], node_rd[g], node_addr[g], mac_start[g], res_valid[g], res_class[g], res_err[g], busy[g]},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    rst = 1'b0;
    tt[0] = 10'd100;
    at[0] = 16'd100;
    ct[0] = {1'b1, 8'h2A, 1'b1, 8'h55};
    walk(0, 4, 5, "leaf_eq");
    at[0] = 16'd101;
    ct[0] = {1'b1, 8'h2A, 1'b0, 8'h05};
    tt[5] = 10'd3;
    at[5] = 16'd0;
    ct[5] = {1'b1, 8'h07, 1'b1, 8'h09};
    mdel = 2;
    walk(0, 4, 1, "right_then_left");
    spur = 1'b1;
    walk(1, 16, 2, "lat3_spurious");
    spur = 1'b0;
    for (int i = 0; i < 20; i++) ct[i] = {1'b0, 8'(i + 1), 1'b0, 8'(i + 1)};
    mdel = 0;
    walk(0, 4, 0, "chain_d4");
    walk(1, 16, 0, "chain_d16");
    mdel = 20;
    @(negedge clk);
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (mac_start[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mac.reached", 32'(mac_start[0]), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mac.idle", {29'd0, busy[0], res_valid[0], req_ready[0]}, 32'b001);
    repeat (25) @(negedge clk);
    chk("rst_mac.late_done", {28'd0, busy[0], res_valid[0], req_ready[0], node_rd[0]}, 32'b0010);
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 256; i++) begin
        tt[i] = 10'($urandom);
        at[i] = 16'($urandom_range(0, 1023));
        ct[i] = {$urandom_range(0, 2) == 0, 8'($urandom_range(0, 15)), $urandom_range(0, 2) == 0, 8'($urandom_range(0, 15))};
      end
      mdel = $urandom_range(0, 3);
      spur = $urandom_range(0, 1) == 1;
      walk(k % 2, k % 2 == 0 ? 4 : 16, $urandom_range(0, 3), "random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
